// File: rtl/enc_bundler_pkg.sv
// rtl/enc_bundler_pkg.sv - shared encoder constants and bundler state type
package enc_bundler_pkg;

  localparam int HV_DIM           = 1024;
  localparam int NUM_IN           = 8;
  localparam int TOTAL_FEATURES   = 617;
  localparam int FEATURES_PER_CC  = NUM_IN;
  localparam int SHIFTS           = NUM_IN;
  localparam int BUNDLE_THRESHOLD = 4;
  localparam int MAX_BEATS        = (TOTAL_FEATURES + NUM_IN - 1) / NUM_IN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2,
    HOLD   = 2'd3
  } bnd_state_t;

endpackage

// File: rtl/enc_bundler_bundle_counter.sv
// rtl/enc_bundler_bundle_counter.sv - one dimension's popcount plus saturating vote accumulator
module bundle_counter
  import enc_bundler_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [NUM_IN-1:0] bits_i,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam int POP_W = $clog2(NUM_IN + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pop = pop + POP_W'(bits_i[i]);
    end
    // One spare bit catches the carry so the count pins at all-ones instead of wrapping.
    sum   = {1'b0, cnt_q} + (CNT_W + 1)'(pop);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (add_i) begin
      cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/enc_bundler.sv
// rtl/enc_bundler.sv - accumulates per-dimension votes over a sample and thresholds them into the sample HV
module enc_bundler
  import enc_bundler_pkg::*;
#(
  parameter int HV_DIM    = enc_bundler_pkg::HV_DIM,
  parameter int NUM_IN    = enc_bundler_pkg::NUM_IN,
  parameter int MAX_BEATS = enc_bundler_pkg::MAX_BEATS,
  parameter int THRESHOLD = enc_bundler_pkg::BUNDLE_THRESHOLD
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_bundling,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [HV_DIM-1:0] in_hv [0:NUM_IN-1],
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_hv,
  output logic              busy,
  output logic              err_overflow
);

  localparam int CNT_W = $clog2(NUM_IN * MAX_BEATS + 1);
  localparam int BW    = $clog2(MAX_BEATS + 1);

  bnd_state_t        state_q, state_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [HV_DIM-1:0] out_hv_q, out_hv_d;
  logic              err_q, err_d;
  logic              clr, accept;
  logic [HV_DIM-1:0] hv_thr;

  for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
    logic [NUM_IN-1:0] col;
    logic [CNT_W-1:0]  cnt;

    always_comb begin
      col = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        col[i] = in_hv[i][d];
      end
    end

    bundle_counter #(
      .NUM_IN(NUM_IN),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .nrst  (nrst),
      .clr_i (clr),
      .add_i (accept),
      .bits_i(col),
      .cnt_o (cnt)
    );

    assign hv_thr[d] = (cnt >= CNT_W'(THRESHOLD));
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_hv_d    = out_hv_q;
    err_d       = err_q;
    clr         = 1'b0;
    accept      = 1'b0;
    // A restart wins over everything, including a beat offered in the same cycle.
    if (start_bundling) begin
      clr         = 1'b1;
      beat_cnt_d  = '0;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            accept = 1'b1;
            // beat_cnt parks at MAX_BEATS so every further beat keeps flagging overflow.
            if (beat_cnt_q == BW'(MAX_BEATS)) begin
              err_d = 1'b1;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (in_last) begin
              state_d = THRESH;
            end
          end
        end
        THRESH: begin
          out_hv_d    = hv_thr;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_hv_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_hv_q    <= out_hv_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_valid_q;
  assign out_hv       = out_hv_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_enc_bundler.sv
// tb/tb_enc_bundler.sv - directed table and sequence checks for enc_bundler
module tb_enc_bundler;

  localparam int HV_DIM    = 1024;
  localparam int NUM_IN    = 8;
  localparam int MAX_BEATS = 4;
  localparam int THRESHOLD = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic              start_bundling;
  logic              in_valid;
  logic              in_last;
  logic [HV_DIM-1:0] in_hv [0:NUM_IN-1];
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] out_hv;
  logic              busy;
  logic              err_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int   dim;
    int   k;
    logic exp_bit;
  } vec_t;

  vec_t              tbl [7];
  logic [HV_DIM-1:0] exp_hv;
  logic [HV_DIM-1:0] held_hv;

  enc_bundler #(
    .HV_DIM   (HV_DIM),
    .NUM_IN   (NUM_IN),
    .MAX_BEATS(MAX_BEATS),
    .THRESHOLD(THRESHOLD)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .start_bundling(start_bundling),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_hv         (in_hv),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_hv        (out_hv),
    .busy          (busy),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [HV_DIM-1:0] act, input logic [HV_DIM-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hv();
    for (int i = 0; i < NUM_IN; i++) in_hv[i] = '0;
  endtask

  task automatic set_bit(input int d, input int k);
    for (int i = 0; i < k; i++) in_hv[i][d] = 1'b1;
  endtask

  task automatic beat(input logic last);
    in_valid = 1'b1;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear_hv();
  endtask

  task automatic start();
    start_bundling = 1'b1;
    step();
    start_bundling = 1'b0;
  endtask

  initial begin
    tbl[0] = '{dim: 5,    k: 4, exp_bit: 1'b1};
    tbl[1] = '{dim: 9,    k: 3, exp_bit: 1'b0};
    tbl[2] = '{dim: 0,    k: 8, exp_bit: 1'b1};
    tbl[3] = '{dim: 1023, k: 4, exp_bit: 1'b1};
    tbl[4] = '{dim: 512,  k: 0, exp_bit: 1'b0};
    tbl[5] = '{dim: 7,    k: 5, exp_bit: 1'b1};
    tbl[6] = '{dim: 100,  k: 1, exp_bit: 1'b0};

    nrst = 1'b1; start_bundling = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    clear_hv();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_hv", out_hv, '0);
    check("rst_err", err_overflow, 1'b0);
    step(); step();
    nrst = 1'b0;
    step();
    check("idle_in_ready", in_ready, 1'b0);

    for (int v = 0; v < 7; v++) begin
      start();
      set_bit(tbl[v].dim, tbl[v].k);
      beat(1'b1);
      check($sformatf("vec%0d_lat1_valid", v), out_valid, 1'b0);
      step();
      check($sformatf("vec%0d_lat2_valid", v), out_valid, 1'b1);
      exp_hv = '0;
      exp_hv[tbl[v].dim] = tbl[v].exp_bit;
      check($sformatf("vec%0d_out_hv", v), out_hv, exp_hv);
      step();
      check($sformatf("vec%0d_idle", v), busy, 1'b0);
    end

    start();
    set_bit(5, 4); set_bit(9, 3);
    beat(1'b1);
    check("pair_lat1_valid", out_valid, 1'b0);
    step();
    check("pair_lat2_valid", out_valid, 1'b1);
    exp_hv = '0; exp_hv[5] = 1'b1;
    check("pair_out_hv", out_hv, exp_hv);
    step();

    start();
    for (int b = 0; b < 3; b++) begin
      set_bit(3, 2);
      beat(1'b0);
    end
    #3 nrst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_hv", out_hv, '0);
    step();
    nrst = 1'b0;
    start();
    set_bit(3, 2); set_bit(4, 4);
    beat(1'b1);
    step();
    exp_hv = '0; exp_hv[4] = 1'b1;
    check("postrst_valid", out_valid, 1'b1);
    check("postrst_out_hv", out_hv, exp_hv);
    step();

    start();
    for (int b = 0; b < 3; b++) begin
      set_bit(0, 2);
      if (b == 1) set_bit(1, 3);
      beat(b == 2);
      if (b < 2) begin
        set_bit(0, 8);
        in_last = 1'b1;
        step(); step();
        in_last = 1'b0;
        clear_hv();
        check($sformatf("gap%0d_still_accum", b), in_ready, 1'b1);
      end
    end
    step();
    exp_hv = '0; exp_hv[0] = 1'b1;
    check("multi_valid", out_valid, 1'b1);
    check("multi_out_hv", out_hv, exp_hv);
    step();

    out_ready = 1'b0;
    start();
    set_bit(5, 8);
    beat(1'b1);
    step();
    exp_hv = '0; exp_hv[5] = 1'b1;
    check("bp_first_hv", out_hv, exp_hv);
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bp_valid_c%0d", c), out_valid, 1'b1);
      check($sformatf("bp_hv_c%0d", c), out_hv, exp_hv);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_hv_kept", out_hv, exp_hv);

    out_ready = 1'b0;
    start();
    set_bit(5, 8);
    beat(1'b1);
    step();
    check("restart_in_hold", out_valid, 1'b1);
    start_bundling = 1'b1;
    in_valid = 1'b1;
    set_bit(6, 8);
    step();
    start_bundling = 1'b0;
    in_valid = 1'b0;
    clear_hv();
    check("restart_valid_drop", out_valid, 1'b0);
    check("restart_accum", in_ready, 1'b1);
    set_bit(7, 4);
    beat(1'b1);
    step();
    exp_hv = '0; exp_hv[7] = 1'b1;
    check("restart_out_hv", out_hv, exp_hv);
    out_ready = 1'b1;
    step();

    start();
    for (int b = 1; b <= 6; b++) begin
      for (int i = 0; i < NUM_IN; i++) in_hv[i] = '1;
      beat(b == 6);
      if (b == 4) check("ovf_before", err_overflow, 1'b0);
      if (b == 5) check("ovf_set", err_overflow, 1'b1);
    end
    step();
    check("ovf_valid", out_valid, 1'b1);
    check("ovf_out_hv", out_hv, '1);
    check("ovf_sticky", err_overflow, 1'b1);
    step();
    start();
    check("ovf_cleared", err_overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
